// File: rtl/seq_controller_param.sv
// Multi-cycle CPU controller: fetch/decode/execute/memory/write-back sequencing with
// configurable wait states, ARM condition squashing, HLT/resume and a retired counter.
module seq_controller_param #(
  parameter int FETCH_WAIT = 1,
  parameter int MEM_WAIT   = 1,
  parameter int CNT_W      = 4,
  parameter int RET_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [3:0]       cond,
  input  logic [31:0]      status_reg,
  input  logic             P,
  input  logic             U,
  input  logic             en_status_decode,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             waiting,
  output logic             halted,
  output logic             load_pc,
  output logic [1:0]       sel_pc,
  output logic             load_ir,
  output logic             en_A,
  output logic             en_B,
  output logic             en_S,
  output logic             en_C,
  output logic             sel_shift,
  output logic             sel_A,
  output logic             sel_B,
  output logic             sel_post_shift,
  output logic [2:0]       ALU_op,
  output logic             en_status,
  output logic             w_en1,
  output logic             w_en3,
  output logic             ram_w_en2,
  output logic             retired,
  output logic [RET_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_RESET, S_LOAD_PC_START, S_LOAD_PC_LOOP, S_FETCH, S_FETCH_WAIT, S_DECODE,
    S_EXECUTE, S_MEMORY, S_MEMORY_WAIT, S_WRITE_BACK, S_HALTED
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RET_W-1:0] r_instr_count;

  logic w_is_alu, w_is_ls, w_is_str, w_is_hlt, w_pass, w_unused;

  function automatic logic cond_pass(input logic [3:0] c, input logic n, z, cf, v);
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = !cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cf & !z;
      4'b1001: cond_pass = !cf | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] alu_decode(input logic [2:0] f);
    case (f)
      3'b001, 3'b010: alu_decode = 3'b001;
      3'b011:         alu_decode = 3'b010;
      3'b100:         alu_decode = 3'b011;
      3'b101:         alu_decode = 3'b111;
      default:        alu_decode = 3'b000;
    endcase
  endfunction

  assign w_is_alu = !opcode[6] && (cond != 4'b1111);
  assign w_is_ls  = (opcode[6:5] == 2'b11) || (opcode[6:3] == 4'b1000);
  assign w_is_str = w_is_ls && opcode[4];
  assign w_is_hlt = (opcode == 7'b0000001);
  assign w_pass   = cond_pass(cond, status_reg[31], status_reg[30], status_reg[29], status_reg[28]);
  assign w_unused = ^status_reg[27:0];
  assign instr_count = r_instr_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RESET;
      r_cnt         <= '0;
      r_instr_count <= '0;
    end else begin
      if (retired) r_instr_count <= r_instr_count + RET_W'(1);
      case (r_state)
        S_RESET:         r_state <= S_LOAD_PC_START;
        S_LOAD_PC_START: r_state <= S_FETCH;
        S_LOAD_PC_LOOP:  r_state <= S_FETCH;
        S_FETCH: begin
          r_cnt   <= CNT_W'(FETCH_WAIT - 1);
          r_state <= S_FETCH_WAIT;
        end
        // Both wait states count down first, then hold until the RAM is ready.
        S_FETCH_WAIT, S_MEMORY_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          else if (mem_ready)
            r_state <= (r_state == S_FETCH_WAIT) ? S_DECODE : S_WRITE_BACK;
        end
        S_DECODE: r_state <= S_EXECUTE;
        S_EXECUTE: begin
          if (!w_pass)       r_state <= S_LOAD_PC_LOOP;
          else if (w_is_hlt) r_state <= S_HALTED;
          else               r_state <= S_MEMORY;
        end
        S_MEMORY: begin
          if (!w_is_alu && w_is_ls) begin
            r_cnt   <= CNT_W'(MEM_WAIT - 1);
            r_state <= S_MEMORY_WAIT;
          end else begin
            r_state <= S_WRITE_BACK;
          end
        end
        S_WRITE_BACK: r_state <= S_LOAD_PC_LOOP;
        S_HALTED:     if (resume) r_state <= S_LOAD_PC_LOOP;
        default:      r_state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    waiting        = (r_state != S_HALTED);
    halted         = 1'b0;
    load_pc        = 1'b0;
    sel_pc         = 2'b00;
    load_ir        = 1'b0;
    en_A           = 1'b0;
    en_B           = 1'b0;
    en_S           = 1'b0;
    en_C           = 1'b0;
    sel_shift      = 1'b0;
    sel_A          = 1'b0;
    sel_B          = 1'b0;
    sel_post_shift = 1'b0;
    ALU_op         = 3'b000;
    en_status      = 1'b0;
    w_en1          = 1'b0;
    w_en3          = 1'b0;
    ram_w_en2      = 1'b0;
    retired        = 1'b0;
    case (r_state)
      S_LOAD_PC_START: begin
        load_pc = 1'b1;
        sel_pc  = 2'b01;
      end
      S_LOAD_PC_LOOP: load_pc = 1'b1;
      S_DECODE:       load_ir = 1'b1;
      S_EXECUTE: begin
        if (!w_pass || w_is_hlt) begin
          retired = 1'b1;
        end else if (w_is_alu) begin
          en_A      = opcode[3];
          en_B      = opcode[4];
          en_S      = 1'b1;
          sel_shift = opcode[4] & opcode[5];
        end else if (w_is_ls) begin
          en_A      = 1'b1;
          en_B      = opcode[3];
          en_S      = opcode[3];
          sel_shift = opcode[3];
        end
      end
      S_MEMORY: begin
        en_C = 1'b1;
        if (w_is_alu) begin
          ALU_op    = alu_decode(opcode[2:0]);
          sel_A     = !opcode[3];
          sel_B     = !opcode[4];
          en_status = en_status_decode;
          w_en1     = (opcode[3:0] != 4'b1010);
        end else if (w_is_ls) begin
          ALU_op         = U ? 3'b000 : 3'b001;
          sel_B          = !opcode[3];
          sel_post_shift = !P;
          en_status      = en_status_decode;
          ram_w_en2      = w_is_str;
        end
      end
      S_WRITE_BACK: begin
        w_en3   = (opcode[6:4] == 3'b110) || (opcode[6:3] == 4'b1000);
        retired = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_controller_param.sv
// Bench for seq_controller_param: default-parameter instance driven from a vector table,
// plus a FETCH_WAIT=3/MEM_WAIT=2/RET_W=2 instance for stall, wrap and async-reset cases.
module tb_seq_controller_param;

  localparam logic [21:0] K_W   = 22'h200000;
  localparam logic [21:0] K_HLT = 22'h100000;
  localparam logic [21:0] K_LPC = 22'h080000;
  localparam logic [21:0] K_SP1 = 22'h020000;
  localparam logic [21:0] K_LIR = 22'h010000;
  localparam logic [21:0] K_EA  = 22'h008000;
  localparam logic [21:0] K_EB  = 22'h004000;
  localparam logic [21:0] K_ES  = 22'h002000;
  localparam logic [21:0] K_EC  = 22'h001000;
  localparam logic [21:0] K_SSH = 22'h000800;
  localparam logic [21:0] K_SA  = 22'h000400;
  localparam logic [21:0] K_SB  = 22'h000200;
  localparam logic [21:0] K_SPS = 22'h000100;
  localparam logic [21:0] K_SUB = 22'h000020;
  localparam logic [21:0] K_AND = 22'h000040;
  localparam logic [21:0] K_ORR = 22'h000060;
  localparam logic [21:0] K_XOR = 22'h0000E0;
  localparam logic [21:0] K_EST = 22'h000010;
  localparam logic [21:0] K_W1  = 22'h000008;
  localparam logic [21:0] K_W3  = 22'h000004;
  localparam logic [21:0] K_RW  = 22'h000002;
  localparam logic [21:0] K_RET = 22'h000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, P, U, esd, mem_ready, resume;
  logic [6:0]  opcode;
  logic [3:0]  cond;
  logic [31:0] status_reg;

  logic        waiting0, halted0, load_pc0, load_ir0, en_A0, en_B0, en_S0, en_C0;
  logic        sel_shift0, sel_A0, sel_B0, sel_ps0, en_status0, w_en1_0, w_en3_0, ram0, retired0;
  logic [1:0]  sel_pc0;
  logic [2:0]  alu0;
  logic [15:0] cnt0;
  logic        waiting1, halted1, load_pc1, load_ir1, en_A1, en_B1, en_S1, en_C1;
  logic        sel_shift1, sel_A1, sel_B1, sel_ps1, en_status1, w_en1_1, w_en3_1, ram1, retired1;
  logic [1:0]  sel_pc1;
  logic [2:0]  alu1;
  logic [1:0]  cnt1;
  logic [21:0] obs0, obs1;

  assign obs0 = {waiting0, halted0, load_pc0, sel_pc0, load_ir0, en_A0, en_B0, en_S0, en_C0,
                 sel_shift0, sel_A0, sel_B0, sel_ps0, alu0, en_status0, w_en1_0, w_en3_0, ram0, retired0};
  assign obs1 = {waiting1, halted1, load_pc1, sel_pc1, load_ir1, en_A1, en_B1, en_S1, en_C1,
                 sel_shift1, sel_A1, sel_B1, sel_ps1, alu1, en_status1, w_en1_1, w_en3_1, ram1, retired1};

  seq_controller_param dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .status_reg(status_reg), .P(P), .U(U),
    .en_status_decode(esd), .mem_ready(mem_ready), .resume(resume),
    .waiting(waiting0), .halted(halted0), .load_pc(load_pc0), .sel_pc(sel_pc0), .load_ir(load_ir0),
    .en_A(en_A0), .en_B(en_B0), .en_S(en_S0), .en_C(en_C0), .sel_shift(sel_shift0),
    .sel_A(sel_A0), .sel_B(sel_B0), .sel_post_shift(sel_ps0), .ALU_op(alu0), .en_status(en_status0),
    .w_en1(w_en1_0), .w_en3(w_en3_0), .ram_w_en2(ram0), .retired(retired0), .instr_count(cnt0)
  );

  seq_controller_param #(.FETCH_WAIT(3), .MEM_WAIT(2), .CNT_W(4), .RET_W(2)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .status_reg(status_reg), .P(P), .U(U),
    .en_status_decode(esd), .mem_ready(mem_ready), .resume(resume),
    .waiting(waiting1), .halted(halted1), .load_pc(load_pc1), .sel_pc(sel_pc1), .load_ir(load_ir1),
    .en_A(en_A1), .en_B(en_B1), .en_S(en_S1), .en_C(en_C1), .sel_shift(sel_shift1),
    .sel_A(sel_A1), .sel_B(sel_B1), .sel_post_shift(sel_ps1), .ALU_op(alu1), .en_status(en_status1),
    .w_en1(w_en1_1), .w_en3(w_en3_1), .ram_w_en2(ram1), .retired(retired1), .instr_count(cnt1)
  );

  typedef struct {
    logic [6:0]  op;
    logic [3:0]  cnd;
    logic [3:0]  nzcv;
    logic        p, u, e, sq;
    int          mw;
    logic [21:0] ex, mem, wb;
  } vec_t;

  typedef struct {
    logic [21:0] exp;
    logic        mr;
    string       nm;
  } sb_t;

  sb_t q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic cmp(input string nm, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [21:0] e, input logic mr, input string nm);
    sb_t s;
    s.exp = e; s.mr = mr; s.nm = nm;
    q.push_back(s);
  endtask

  task automatic push_instr(input logic [21:0] first, input int fw, input bit sq, input int mw,
                            input logic [21:0] ex, input logic [21:0] mem, input logic [21:0] wb);
    push(first, 1'b1, "pc");
    push(K_W, 1'b1, "fetch");
    repeat (fw) push(K_W, 1'b1, "fetch_wait");
    push(K_W | K_LIR, 1'b1, "decode");
    push(ex, 1'b1, "execute");
    if (!sq) begin
      push(mem, 1'b1, "memory");
      repeat (mw) push(K_W, 1'b1, "memory_wait");
      push(wb, 1'b1, "write_back");
    end
  endtask

  // Each entry: drive its mem_ready, compare at the falling edge, advance past the next rising edge.
  task automatic drain(input bit sel, input string pfx);
    while (q.size() > 0) begin
      sb_t s;
      s = q.pop_front();
      mem_ready = s.mr;
      @(negedge clk);
      cmp($sformatf("%s_%s", pfx, s.nm), sel ? obs1 : obs0, s.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [6:0] op, input logic [3:0] c, input logic [3:0] f,
                        input logic p, input logic u, input logic e);
    opcode = op; cond = c; status_reg = {f, 28'h0}; P = p; U = u; esd = e;
  endtask

  vec_t tbl[17];
  int   exp_seq[4] = '{2, 3, 0, 1};
  logic [15:0] exp0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{7'b0011000, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, K_W|K_EA|K_EB|K_ES, K_W|K_EC|K_W1, K_W|K_RET};
    tbl[1]  = '{7'b0110001, 4'b0001, 4'b0000, 0, 0, 1, 0, 0, K_W|K_EB|K_ES|K_SSH, K_W|K_EC|K_SA|K_SUB|K_EST|K_W1, K_W|K_RET};
    tbl[2]  = '{7'b0001010, 4'b0000, 4'b0100, 0, 0, 1, 0, 0, K_W|K_EA|K_ES, K_W|K_EC|K_SB|K_SUB|K_EST, K_W|K_RET};
    tbl[3]  = '{7'b0000101, 4'b1010, 4'b1001, 0, 0, 0, 0, 0, K_W|K_ES, K_W|K_EC|K_SA|K_SB|K_XOR|K_W1, K_W|K_RET};
    tbl[4]  = '{7'b0001100, 4'b1000, 4'b0010, 0, 0, 0, 0, 0, K_W|K_EA|K_ES, K_W|K_EC|K_SB|K_ORR|K_W1, K_W|K_RET};
    tbl[5]  = '{7'b0000011, 4'b1101, 4'b0100, 0, 0, 0, 0, 0, K_W|K_ES, K_W|K_EC|K_SA|K_SB|K_AND|K_W1, K_W|K_RET};
    tbl[6]  = '{7'b0001110, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, K_W|K_EA|K_ES, K_W|K_EC|K_SB|K_W1, K_W|K_RET};
    tbl[7]  = '{7'b0011000, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, K_W|K_RET, '0, '0};
    tbl[8]  = '{7'b0100000, 4'b1011, 4'b0000, 0, 0, 0, 1, 0, K_W|K_RET, '0, '0};
    tbl[9]  = '{7'b0011000, 4'b1100, 4'b0100, 0, 0, 0, 1, 0, K_W|K_RET, '0, '0};
    tbl[10] = '{7'b1100000, 4'b1110, 4'b0000, 1, 1, 0, 0, 1, K_W|K_EA, K_W|K_EC|K_SB, K_W|K_W3|K_RET};
    tbl[11] = '{7'b1111000, 4'b1110, 4'b0000, 0, 0, 1, 0, 1, K_W|K_EA|K_EB|K_ES|K_SSH, K_W|K_EC|K_SUB|K_SPS|K_EST|K_RW, K_W|K_RET};
    tbl[12] = '{7'b1000011, 4'b1110, 4'b0000, 0, 1, 0, 0, 1, K_W|K_EA, K_W|K_EC|K_SB|K_SPS, K_W|K_W3|K_RET};
    tbl[13] = '{7'b1010000, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, K_W, K_W|K_EC, K_W|K_RET};
    tbl[14] = '{7'b0011000, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, K_W, K_W|K_EC, K_W|K_RET};
    tbl[15] = '{7'b0000001, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, K_W|K_RET, '0, '0};
    tbl[16] = '{7'b1100000, 4'b0110, 4'b0000, 1, 1, 0, 1, 0, K_W|K_RET, '0, '0};

    rst = 1'b1; mem_ready = 1'b1; resume = 1'b0;
    set_in(7'b0011000, 4'b1110, 4'b0000, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset_out0", obs0, K_W);
    cmp("reset_out1", obs1, K_W);
    cmp("reset_cnt0", 22'(cnt0), 22'd0);
    cmp("reset_cnt1", 22'(cnt1), 22'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First ADD after reset: start vector on cycle 1, load_ir on 4, retire on 7.
    push(K_W, 1'b1, "reset_idle");
    push_instr(K_W|K_LPC|K_SP1, 1, 0, 0, tbl[0].ex, tbl[0].mem, tbl[0].wb);
    drain(0, "first_add");
    exp0 = 16'd1;
    cmp("first_add_count", 22'(cnt0), 22'(exp0));

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].op, tbl[i].cnd, tbl[i].nzcv, tbl[i].p, tbl[i].u, tbl[i].e);
      resume = (i == 13);
      push_instr(K_W|K_LPC, 1, tbl[i].sq, tbl[i].mw, tbl[i].ex, tbl[i].mem, tbl[i].wb);
      drain(0, $sformatf("vec%0d", i));
      exp0 = exp0 + 16'd1;
      cmp($sformatf("vec%0d_count", i), 22'(cnt0), 22'(exp0));
    end
    resume = 1'b0;

    // HLT: halt for 10 cycles, then a resume pulse restarts at the PC loop state.
    set_in(7'b0000001, 4'b1110, 4'b0000, 0, 0, 0);
    push_instr(K_W|K_LPC, 1, 1, 0, K_W|K_RET, '0, '0);
    repeat (10) push(K_HLT, 1'b1, "halted");
    drain(0, "hlt");
    exp0 = exp0 + 16'd1;
    cmp("hlt_count", 22'(cnt0), 22'(exp0));
    resume = 1'b1;
    push(K_HLT, 1'b1, "resume_cycle");
    drain(0, "hlt");
    resume = 1'b0;
    push(K_W|K_LPC, 1'b1, "after_resume");
    drain(0, "hlt");
    cmp("resume_count", 22'(cnt0), 22'(exp0));

    // LDR with RAM stalling two extra cycles in MEMORY_WAIT.
    set_in(7'b1100000, 4'b1110, 4'b0000, 1, 1, 0);
    push(K_W, 1'b1, "fetch");
    push(K_W, 1'b1, "fetch_wait");
    push(K_W|K_LIR, 1'b1, "decode");
    push(K_W|K_EA, 1'b1, "execute");
    push(K_W|K_EC|K_SB, 1'b1, "memory");
    push(K_W, 1'b0, "mw_stall0");
    push(K_W, 1'b0, "mw_stall1");
    push(K_W, 1'b1, "mw_ready");
    push(K_W|K_W3|K_RET, 1'b1, "write_back");
    drain(0, "ldr_stall");
    exp0 = exp0 + 16'd1;
    cmp("ldr_stall_count", 22'(cnt0), 22'(exp0));

    // Second instance: STR with FETCH_WAIT=3 and a two-cycle RAM stall after the count expires.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(7'b1111000, 4'b1110, 4'b0000, 0, 0, 0);
    push(K_W, 1'b1, "reset_idle");
    push(K_W|K_LPC|K_SP1, 1'b1, "start");
    push(K_W, 1'b1, "fetch");
    push(K_W, 1'b1, "fw_cnt2");
    push(K_W, 1'b1, "fw_cnt1");
    push(K_W, 1'b0, "fw_stall0");
    push(K_W, 1'b0, "fw_stall1");
    push(K_W, 1'b1, "fw_ready");
    push(K_W|K_LIR, 1'b1, "decode");
    push(K_W|K_EA|K_EB|K_ES|K_SSH, 1'b1, "execute");
    push(K_W|K_EC|K_SUB|K_SPS|K_RW, 1'b1, "memory");
    push(K_W, 1'b1, "mw_cnt1");
    push(K_W, 1'b1, "mw_cnt0");
    push(K_W|K_RET, 1'b1, "write_back");
    drain(1, "str");
    cmp("str_count", 22'(cnt1), 22'd1);

    set_in(7'b0011000, 4'b1110, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      push_instr(K_W|K_LPC, 3, 0, 0, tbl[0].ex, tbl[0].mem, tbl[0].wb);
      drain(1, $sformatf("wrap%0d", k));
      cmp($sformatf("wrap%0d_count", k), 22'(cnt1), 22'(exp_seq[k]));
    end

    // Asynchronous reset while the second instance sits in MEMORY_WAIT.
    set_in(7'b1111000, 4'b1110, 4'b0000, 0, 0, 0);
    push_instr(K_W|K_LPC, 3, 1, 0, K_W|K_EA|K_EB|K_ES|K_SSH, '0, '0);
    push(K_W|K_EC|K_SUB|K_SPS|K_RW, 1'b1, "memory");
    drain(1, "rst_mid");
    #2;
    cmp("rst_mid_before", obs1, K_W);
    rst = 1'b1;
    #1;
    cmp("rst_mid_out1", obs1, K_W);
    cmp("rst_mid_cnt1", 22'(cnt1), 22'd0);
    cmp("rst_mid_out0", obs0, K_W);
    cmp("rst_mid_cnt0", 22'(cnt0), 22'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(K_W, 1'b1, "reset_idle");
    push(K_W|K_LPC|K_SP1, 1'b1, "start");
    drain(1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
